// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits added per pipeline stage.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Control fields carried in every stage register.
    typedef struct packed {
        logic valid;
        logic op;
        logic carry;
    } stage_ctrl_t;

endpackage

// File: rtl/addsub_slice.sv
// CHUNK-bit ripple adder slice built from full_adder cells.
// Latency: combinational.
// Backpressure: n/a.
module addsub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (s_o[i]),
            .c_o (c[i+1])
        );
    end

    // Carry out of the slice, and the carry into its top bit (used for signed overflow).
    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational.
// Backpressure: n/a.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub, one CHUNK-bit slice per stage, with status flags and tag passthrough.
// Latency: STAGES cycles from input transfer to out_valid_o; 1 op/cycle throughput.
// Backpressure: global stall; when out_valid_o && !out_ready_i every stage holds and in_ready_o drops.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
    end

    // a/b hold the operands (b already inverted for SUB); s accumulates finished low slices.
    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             ovf;
        logic             zero;
        logic             neg;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    stage_t src  [STAGES];

    logic [CHUNK-1:0] sl_a    [STAGES];
    logic [CHUNK-1:0] sl_b    [STAGES];
    logic [CHUNK-1:0] sl_s    [STAGES];
    logic             sl_cin  [STAGES];
    logic             sl_cout [STAGES];
    logic             sl_cmsb [STAGES];

    logic adv;

    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    // What enters each stage on an advance: the new op for stage 0, otherwise the previous stage.
    always_comb begin
        src[0]            = '0;
        src[0].ctrl.valid = in_valid_i;
        src[0].ctrl.op    = op_i;
        src[0].ctrl.carry = op_i;
        src[0].tag        = tag_i;
        src[0].a          = a_i;
        src[0].b          = b_i ^ {WIDTH{op_i}};
        for (int k = 1; k < STAGES; k++) begin
            src[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign sl_a[k]   = src[k].a[k*CHUNK +: CHUNK];
        assign sl_b[k]   = src[k].b[k*CHUNK +: CHUNK];
        assign sl_cin[k] = src[k].ctrl.carry;

        addsub_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a_i    (sl_a[k]),
            .b_i    (sl_b[k]),
            .cin_i  (sl_cin[k]),
            .s_o    (sl_s[k]),
            .cout_o (sl_cout[k]),
            .cmsb_o (sl_cmsb[k])
        );
    end

    // Shift all stages together on advance; bubbles carry an all-zero payload so idle outputs read 0.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_d[k] = st_q[k];
            if (adv) begin
                if (src[k].ctrl.valid) begin
                    st_d[k]                     = src[k];
                    st_d[k].s[k*CHUNK +: CHUNK] = sl_s[k];
                    st_d[k].ctrl.carry          = sl_cout[k];
                    if (k == LAST) begin
                        st_d[k].ovf  = sl_cmsb[k] ^ sl_cout[k];
                        st_d[k].zero = (st_d[k].s == '0);
                        st_d[k].neg  = st_d[k].s[WIDTH-1];
                    end
                end else begin
                    st_d[k] = '0;
                end
            end
        end
    end

    // Synchronous reset drops every in-flight op and clears the output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign out_valid_o = st_q[LAST].ctrl.valid;
    assign sum_o       = st_q[LAST].s;
    assign tag_o       = st_q[LAST].tag;
    assign carry_o     = st_q[LAST].ctrl.carry;
    assign ovf_o       = st_q[LAST].ovf;
    assign zero_o      = st_q[LAST].zero;
    assign neg_o       = st_q[LAST].neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, STAGES=4, TAG_W=4).
// Latency: expects results exactly 4 cycles after acceptance when not stalled.
// Backpressure: exercises a 3-cycle output stall and a reset with ops in flight.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready_o;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        op_in;
    logic [3:0]  tag_in;
    logic        out_valid_o;
    logic        out_ready;
    logic [31:0] sum_o;
    logic [3:0]  tag_o;
    logic        carry_o;
    logic        ovf_o;
    logic        zero_o;
    logic        neg_o;

    pipelined_addsub #(
        .WIDTH  (32),
        .STAGES (4),
        .TAG_W  (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .a_i         (a_in),
        .b_i         (b_in),
        .op_i        (op_in),
        .tag_i       (tag_in),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .sum_o       (sum_o),
        .tag_o       (tag_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o),
        .neg_o       (neg_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  tag;
        logic        c, v, z, n;
        bit          lat;
        int          t;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        op;
        logic [31:0] s;
        logic        c, v, z, n;
    } vec_t;

    exp_t q[$];
    vec_t tbl[10];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rx    = 0;
    bit   held  = 0;
    logic [31:0] h_sum;
    logic [3:0]  h_tag;
    logic        h_flags;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic op, input logic [3:0] tag, input bit lat);
        exp_t e;
        logic [31:0] r;
        r     = op ? (a - b) : (a + b);
        e.sum = r;
        e.tag = tag;
        e.c   = op ? (a >= b) : ({1'b0, a} + {1'b0, b} > 33'hFFFF_FFFF);
        e.v   = op ? ((a[31] != b[31]) && (r[31] != a[31]))
                   : ((a[31] == b[31]) && (r[31] != a[31]));
        e.z   = (r == 32'd0);
        e.n   = r[31];
        e.lat = lat;
        e.t   = 0;
        return e;
    endfunction

    // Offer one op and hold it until accepted; the expectation is queued at acceptance.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input exp_t e);
        int   n;
        logic acc;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        op_in    = op;
        tag_in   = e.tag;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready_o;
            if (acc) begin
                e.t = cyc;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: stall stability, scoreboard compare on each output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held) begin
                chk("stall_valid", 64'(out_valid_o), 64'd1);
                chk("stall_sum", 64'(sum_o), 64'(h_sum));
                chk("stall_tag", 64'(tag_o), 64'(h_tag));
                chk("stall_neg", 64'(neg_o), 64'(h_flags));
            end
            held = 1'b0;
            if (out_valid_o && !out_ready) begin
                held    = 1'b1;
                h_sum   = sum_o;
                h_tag   = tag_o;
                h_flags = neg_o;
                chk("stall_in_ready", 64'(in_ready_o), 64'd0);
            end
            if (out_valid_o && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid_o), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", 64'(sum_o), 64'(e.sum));
                    chk("tag", 64'(tag_o), 64'(e.tag));
                    chk("carry", 64'(carry_o), 64'(e.c));
                    chk("ovf", 64'(ovf_o), 64'(e.v));
                    chk("zero", 64'(zero_o), 64'(e.z));
                    chk("neg", 64'(neg_o), 64'(e.n));
                    if (e.lat) chk("latency", 64'(cyc - e.t), 64'd4);
                    rx++;
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   rx0;

        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        op_in     = 1'b0;
        tag_in    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_sum", 64'(sum_o), 64'd0);
        chk("rst_flags", 64'({carry_o, ovf_o, zero_o, neg_o}), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table vectors, issued back-to-back with tags 0..9
        for (int i = 0; i < 10; i++) begin
            e = '{sum: tbl[i].s, tag: 4'(i), c: tbl[i].c, v: tbl[i].v,
                  z: tbl[i].z, n: tbl[i].n, lat: 1'b1, t: 0};
            send(tbl[i].a, tbl[i].b, tbl[i].op, e);
        end
        drain();
        chk("table_count", 64'(rx), 64'd10);

        // Stream of 8 with a 3-cycle output stall once results start flowing
        rx0 = rx;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] a, b;
                    logic        op;
                    a  = $urandom;
                    b  = $urandom;
                    op = 1'($urandom_range(0, 1));
                    send(a, b, op, model(a, b, op, 4'(i), 1'b0));
                end
            end
            begin
                for (int i = 0; i < 40 && !out_valid_o; i++) @(negedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(rx - rx0), 64'd8);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            send(32'(i + 10), 32'd1, 1'b0, model(32'(i + 10), 32'd1, 1'b0, 4'(i + 8), 1'b1));
        end
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk("flush_out_valid", 64'(out_valid_o), 64'd0);
        chk("flush_sum", 64'(sum_o), 64'd0);
        chk("flush_tag", 64'(tag_o), 64'd0);
        chk("flush_flags", 64'({carry_o, ovf_o, zero_o, neg_o}), 64'd0);
        chk("flush_in_ready", 64'(in_ready_o), 64'd1);
        rst_n = 1'b1;
        rx0 = rx;
        repeat (8) @(posedge clk);
        #1;
        chk("flush_no_ghost", 64'(rx - rx0), 64'd0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
             model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'hA, 1'b1));
        drain();
        chk("post_reset_count", 64'(rx - rx0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
